// File: rtl/id_decode_queue_if.sv
// Fetch-to-ID handshake bundle for the decode queue.
// slave = queue side, master = fetch/ID environment side.
interface id_decode_queue_if;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [3:0]  id_class_o;
    logic        id_regwr_o;
    logic [3:0]  id_mdu_op_o;
    logic [1:0]  id_dm_type_o;

    modport slave (
        input  if_valid_i, if_instr_i, if_pc_i, id_ready_i,
        output if_ready_o, id_valid_o, id_instr_o, id_pc_o,
        output id_class_o, id_regwr_o, id_mdu_op_o, id_dm_type_o
    );

    modport master (
        output if_valid_i, if_instr_i, if_pc_i, id_ready_i,
        input  if_ready_o, id_valid_o, id_instr_o, id_pc_o,
        input  id_class_o, id_regwr_o, id_mdu_op_o, id_dm_type_o
    );
endinterface

// File: rtl/id_decode_queue.sv
// Decode front-end: instruction FIFO, pre-classifier, registered output, MDU stall.
// Optional MDU stall-cycle counter enabled by defining ID_PERF_CNT_EN.
module id_decode_queue #(
    parameter int QUEUE_DEPTH = 4,
    parameter int DIV_CYCLES  = 8,
    parameter int MUL_CYCLES  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    id_decode_queue_if.slave   bus,
    output logic               mdu_busy_o,
    output logic [31:0]        perf_stall_cnt_o
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   instr_q [QUEUE_DEPTH];
    logic [31:0]   instr_d [QUEUE_DEPTH];
    logic [31:0]   pc_q    [QUEUE_DEPTH];
    logic [31:0]   pc_d    [QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_instr_q, out_instr_d;
    logic [31:0]   out_pc_q, out_pc_d;
    logic [3:0]    out_class_q, out_class_d;
    logic          out_regwr_q, out_regwr_d;
    logic [3:0]    out_mdu_q, out_mdu_d;
    logic [1:0]    out_dm_q, out_dm_d;

    logic [7:0]    busy_q, busy_d;

    logic [31:0]   head;
    logic [5:0]    op, fn;
    logic [4:0]    rs, rt;
    logic [3:0]    head_class;
    logic          head_regwr;
    logic [3:0]    head_mdu;
    logic [1:0]    head_dm;

    logic          not_empty, push, load, hs, stall;
    logic          out_long, out_div, out_mult;

    assign head = instr_q[rd_ptr_q];
    assign op   = head[31:26];
    assign fn   = head[5:0];
    assign rs   = head[25:21];
    assign rt   = head[20:16];

    // Pre-classify the FIFO head (MIPS32 encodings)
    always_comb begin
        head_class = 4'd0;
        head_regwr = 1'b0;
        head_mdu   = 4'd0;
        head_dm    = 2'd0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                        head_class = 4'd3;
                        head_regwr = 1'b1;
                    end
                    6'h08: head_class = 4'd6;
                    6'h09: begin
                        head_class = 4'd7;
                        head_regwr = 1'b1;
                    end
                    6'h0A, 6'h0B: begin
                        head_class = 4'd1;
                        head_regwr = 1'b1;
                    end
                    6'h0C: head_class = 4'd10;
                    6'h10: begin
                        head_class = 4'd8;
                        head_regwr = 1'b1;
                        head_mdu   = 4'd6;
                    end
                    6'h11: begin
                        head_class = 4'd8;
                        head_mdu   = 4'd8;
                    end
                    6'h12: begin
                        head_class = 4'd8;
                        head_regwr = 1'b1;
                        head_mdu   = 4'd7;
                    end
                    6'h13: begin
                        head_class = 4'd8;
                        head_mdu   = 4'd9;
                    end
                    6'h18: begin
                        head_class = 4'd8;
                        head_mdu   = 4'd4;
                    end
                    6'h19: begin
                        head_class = 4'd8;
                        head_mdu   = 4'd5;
                    end
                    6'h1A: begin
                        head_class = 4'd8;
                        head_mdu   = 4'd1;
                    end
                    6'h1B: begin
                        head_class = 4'd8;
                        head_mdu   = 4'd2;
                    end
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        head_class = 4'd1;
                        head_regwr = 1'b1;
                    end
                    default: ;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'h00, 5'h01: head_class = 4'd6;
                    5'h10, 5'h11: begin
                        head_class = 4'd7;
                        head_regwr = 1'b1;
                    end
                    default: ;
                endcase
            end
            6'h02: head_class = 4'd6;
            6'h03: begin
                head_class = 4'd7;
                head_regwr = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: head_class = 4'd6;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                head_class = 4'd2;
                head_regwr = 1'b1;
            end
            6'h10: begin
                head_class = 4'd9;
                head_regwr = (rs == 5'h00);
            end
            6'h1C: begin
                if (fn == 6'h02) begin
                    head_class = 4'd8;
                    head_regwr = 1'b1;
                    head_mdu   = 4'd3;
                end
            end
            6'h20, 6'h24: begin
                head_class = 4'd4;
                head_regwr = 1'b1;
                head_dm    = 2'd1;
            end
            6'h21, 6'h25: begin
                head_class = 4'd4;
                head_regwr = 1'b1;
                head_dm    = 2'd2;
            end
            6'h23: begin
                head_class = 4'd4;
                head_regwr = 1'b1;
                head_dm    = 2'd3;
            end
            6'h28: begin
                head_class = 4'd5;
                head_dm    = 2'd1;
            end
            6'h29: begin
                head_class = 4'd5;
                head_dm    = 2'd2;
            end
            6'h2B: begin
                head_class = 4'd5;
                head_dm    = 2'd3;
            end
            default: ;
        endcase
    end

    // Handshake, stall and load qualification
    always_comb begin
        not_empty = (count_q != '0);
        out_div   = (out_mdu_q == 4'd1) || (out_mdu_q == 4'd2);
        out_mult  = (out_mdu_q == 4'd4) || (out_mdu_q == 4'd5);
        out_long  = out_valid_q && (out_div || out_mult);
        hs        = out_valid_q && bus.id_ready_i;
        stall     = not_empty && (head_class == 4'd8) &&
                    ((busy_q != 8'd0) || out_long);
        load      = (!out_valid_q || bus.id_ready_i) && not_empty &&
                    !stall && !flush_i;
        push      = bus.if_valid_i && bus.if_ready_o && !flush_i;
    end

    assign bus.if_ready_o = (count_q < CW'(QUEUE_DEPTH));

    // FIFO storage, pointers and occupancy
    always_comb begin
        instr_d  = instr_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = bus.if_instr_i;
                pc_d[wr_ptr_q]    = bus.if_pc_i;
                wr_ptr_d          = wr_ptr_q + 1'b1;
            end
            if (load) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(load);
        end
    end

    // Output register: flush clears, load replaces, accept empties, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_class_d = out_class_q;
        out_regwr_d = out_regwr_q;
        out_mdu_d   = out_mdu_q;
        out_dm_d    = out_dm_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            out_instr_d = head;
            out_pc_d    = pc_q[rd_ptr_q];
            out_class_d = head_class;
            out_regwr_d = head_regwr;
            out_mdu_d   = head_mdu;
            out_dm_d    = head_dm;
        end else if (bus.id_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // MDU busy scoreboard; issued ops complete even across a flush
    always_comb begin
        busy_d = (busy_q != 8'd0) ? busy_q - 8'd1 : 8'd0;
        if (hs && out_div) begin
            busy_d = 8'(DIV_CYCLES);
        end else if (hs && out_mult) begin
            busy_d = 8'(MUL_CYCLES);
        end
    end

    // Storage array needs no reset: occupancy qualifies every read
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_class_q <= '0;
            out_regwr_q <= 1'b0;
            out_mdu_q   <= '0;
            out_dm_q    <= '0;
            busy_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_class_q <= out_class_d;
            out_regwr_q <= out_regwr_d;
            out_mdu_q   <= out_mdu_d;
            out_dm_q    <= out_dm_d;
            busy_q      <= busy_d;
        end
    end

`ifdef ID_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Count cycles where an MDU hazard blocks an otherwise possible load
    always_comb begin
        perf_d = perf_q;
        if (stall && not_empty && (!out_valid_q || bus.id_ready_i)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Perf counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt_o = perf_q;
`else
    assign perf_stall_cnt_o = 32'd0;
`endif

    assign bus.id_valid_o   = out_valid_q;
    assign bus.id_instr_o   = out_instr_q;
    assign bus.id_pc_o      = out_pc_q;
    assign bus.id_class_o   = out_class_q;
    assign bus.id_regwr_o   = out_regwr_q;
    assign bus.id_mdu_op_o  = out_mdu_q;
    assign bus.id_dm_type_o = out_dm_q;
    assign mdu_busy_o       = (busy_q != 8'd0);
endmodule

// File: tb/tb_id_decode_queue.sv
// Bench for id_decode_queue: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_id_decode_queue;
    localparam int D    = 4;
    localparam int DIVC = 8;
    localparam int MULC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        mdu_busy;
    logic [31:0] perf;

    id_decode_queue_if bus();

    id_decode_queue #(
        .QUEUE_DEPTH(D),
        .DIV_CYCLES (DIVC),
        .MUL_CYCLES (MULC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .bus             (bus),
        .mdu_busy_o      (mdu_busy),
        .perf_stall_cnt_o(perf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] free;
        logic [3:0]  cls;
        logic        wr;
        logic [3:0]  mdu;
        logic [1:0]  dm;
    } ent_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  cls;
        logic        wr;
        logic [3:0]  mdu;
        logic [1:0]  dm;
    } beat_t;

    localparam int ADDU = 0, LW = 1, SW = 2, SLL = 3, ADDIU = 4;
    localparam int DIV = 11, MULT = 14, MULTU = 15, MFLO = 17;
    localparam int NT = 29;

    ent_t        tbl [NT];
    beat_t       fifo [$];
    beat_t       out;
    bit          oval;
    longint      cyc;
    longint      free_at;
    logic [31:0] perf_m;
    int          tests;
    int          fails;
    bit          chk_en;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("id_valid", 32'(bus.id_valid_o), 32'(oval));
        chk("if_ready", 32'(bus.if_ready_o), 32'(fifo.size() < D));
        chk("instr", bus.id_instr_o, out.instr);
        chk("pc", bus.id_pc_o, out.pc);
        chk("class", 32'(bus.id_class_o), 32'(out.cls));
        chk("regwr", 32'(bus.id_regwr_o), 32'(out.wr));
        chk("mdu_op", 32'(bus.id_mdu_op_o), 32'(out.mdu));
        chk("dm_type", 32'(bus.id_dm_type_o), 32'(out.dm));
        chk("mdu_busy", 32'(mdu_busy), 32'(cyc < free_at));
`ifdef ID_PERF_CNT_EN
        chk("perf", perf, perf_m);
`else
        chk("perf", perf, 32'd0);
`endif
    endtask

    // One clock: check state, drive inputs, advance the model, clock.
    task automatic step(input bit v, input int idx, input bit rdy,
                        input bit fl, input bit r);
        beat_t b;
        int    sz;
        bit    stall;
        bit    hs;
        bit    load;
        bit    pushok;
        bit    longop;
        @(negedge clk);
        if (chk_en) check_all();
        b.instr = tbl[idx].base | ($urandom() & tbl[idx].free);
        b.pc    = $urandom();
        b.cls   = tbl[idx].cls;
        b.wr    = tbl[idx].wr;
        b.mdu   = tbl[idx].mdu;
        b.dm    = tbl[idx].dm;
        rst            = r;
        flush_i        = fl;
        bus.if_valid_i = v;
        bus.if_instr_i = b.instr;
        bus.if_pc_i    = b.pc;
        bus.id_ready_i = rdy;
        if (r) begin
            fifo.delete();
            oval    = 1'b0;
            out     = '0;
            free_at = cyc + 1;
            perf_m  = '0;
        end else begin
            sz     = fifo.size();
            longop = oval && (out.mdu inside {4'd1, 4'd2, 4'd4, 4'd5});
            stall  = (sz != 0) && (fifo[0].cls == 4'd8) &&
                     ((cyc < free_at) || longop);
            hs     = oval && rdy;
            load   = (!oval || rdy) && (sz != 0) && !stall && !fl;
            pushok = v && (sz < D) && !fl;
            if (stall && (!oval || rdy)) perf_m = perf_m + 32'd1;
            if (hs && (out.mdu inside {4'd1, 4'd2}))
                free_at = cyc + DIVC + 1;
            else if (hs && (out.mdu inside {4'd4, 4'd5}))
                free_at = cyc + MULC + 1;
            if (fl) begin
                fifo.delete();
                oval = 1'b0;
            end else begin
                if (load) begin
                    out  = fifo.pop_front();
                    oval = 1'b1;
                end else if (rdy) begin
                    oval = 1'b0;
                end
                if (pushok) fifo.push_back(b);
            end
        end
        @(posedge clk);
        cyc++;
        if (r) chk_en = 1'b1;
    endtask

    initial begin
        tbl = '{
            '{32'h00000021, 32'h03FFF800, 4'd1,  1'b1, 4'd0, 2'd0},
            '{32'h8C000000, 32'h03FFFFFF, 4'd4,  1'b1, 4'd0, 2'd3},
            '{32'hAC000000, 32'h03FFFFFF, 4'd5,  1'b0, 4'd0, 2'd3},
            '{32'h00000000, 32'h001FFFC0, 4'd3,  1'b1, 4'd0, 2'd0},
            '{32'h24000000, 32'h03FFFFFF, 4'd2,  1'b1, 4'd0, 2'd0},
            '{32'h80000000, 32'h03FFFFFF, 4'd4,  1'b1, 4'd0, 2'd1},
            '{32'hA4000000, 32'h03FFFFFF, 4'd5,  1'b0, 4'd0, 2'd2},
            '{32'h10000000, 32'h03FFFFFF, 4'd6,  1'b0, 4'd0, 2'd0},
            '{32'h0C000000, 32'h03FFFFFF, 4'd7,  1'b1, 4'd0, 2'd0},
            '{32'h00000008, 32'h03E00000, 4'd6,  1'b0, 4'd0, 2'd0},
            '{32'h04110000, 32'h03E0FFFF, 4'd7,  1'b1, 4'd0, 2'd0},
            '{32'h0000001A, 32'h03FF0000, 4'd8,  1'b0, 4'd1, 2'd0},
            '{32'h0000001B, 32'h03FF0000, 4'd8,  1'b0, 4'd2, 2'd0},
            '{32'h70000002, 32'h03FFF800, 4'd8,  1'b1, 4'd3, 2'd0},
            '{32'h00000018, 32'h03FF0000, 4'd8,  1'b0, 4'd4, 2'd0},
            '{32'h00000019, 32'h03FF0000, 4'd8,  1'b0, 4'd5, 2'd0},
            '{32'h00000010, 32'h0000F800, 4'd8,  1'b1, 4'd6, 2'd0},
            '{32'h00000012, 32'h0000F800, 4'd8,  1'b1, 4'd7, 2'd0},
            '{32'h00000011, 32'h03E00000, 4'd8,  1'b0, 4'd8, 2'd0},
            '{32'h00000013, 32'h03E00000, 4'd8,  1'b0, 4'd9, 2'd0},
            '{32'h40000000, 32'h001FF800, 4'd9,  1'b1, 4'd0, 2'd0},
            '{32'h42000018, 32'h00000000, 4'd9,  1'b0, 4'd0, 2'd0},
            '{32'h0000000C, 32'h03FFFFC0, 4'd10, 1'b0, 4'd0, 2'd0},
            '{32'h0000000B, 32'h03FFF800, 4'd1,  1'b1, 4'd0, 2'd0},
            '{32'h0000F809, 32'h03E00000, 4'd7,  1'b1, 4'd0, 2'd0},
            '{32'h94000000, 32'h03FFFFFF, 4'd4,  1'b1, 4'd0, 2'd2},
            '{32'h00000007, 32'h03FFF800, 4'd3,  1'b1, 4'd0, 2'd0},
            '{32'h3C000000, 32'h03FFFFFF, 4'd2,  1'b1, 4'd0, 2'd0},
            '{32'hFC000000, 32'h03FFFFFF, 4'd0,  1'b0, 4'd0, 2'd0}
        };
        tests   = 0;
        fails   = 0;
        cyc     = 0;
        free_at = 0;
        perf_m  = '0;
        oval    = 1'b0;
        out     = '0;
        chk_en  = 1'b0;
        rst            = 1'b1;
        flush_i        = 1'b0;
        bus.if_valid_i = 1'b0;
        bus.if_instr_i = '0;
        bus.if_pc_i    = '0;
        bus.id_ready_i = 1'b0;

        // Reset
        step(0, ADDU, 0, 0, 1);
        step(0, ADDU, 0, 0, 1);

        // ADDU, LW, SW back to back with ready high
        step(1, ADDU, 1, 0, 0);
        step(1, LW, 1, 0, 0);
        step(1, SW, 1, 0, 0);
        repeat (4) step(0, ADDU, 1, 0, 0);

        // Fill with ready low, sixth beat refused, then drain
        for (int i = 0; i < 6; i++) step(1, i % 5, 0, 0, 0);
        repeat (7) step(0, ADDU, 1, 0, 0);

        // DIV then MFLO
        step(1, DIV, 1, 0, 0);
        step(1, MFLO, 1, 0, 0);
        repeat (14) step(0, ADDU, 1, 0, 0);

        // MULT then MULTU
        step(1, MULT, 1, 0, 0);
        step(1, MULTU, 1, 0, 0);
        repeat (8) step(0, ADDU, 1, 0, 0);

        // Flush with an output held and three queued, beat in flush cycle dropped
        for (int i = 0; i < 4; i++) step(1, i + 1, 0, 0, 0);
        step(1, SLL, 0, 1, 0);
        step(1, ADDIU, 1, 0, 0);
        repeat (4) step(0, ADDU, 1, 0, 0);

        // Reset while full and stalled behind a DIV
        step(1, DIV, 0, 0, 0);
        step(1, MFLO, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, ADDU, 0, 0, 0);
        step(0, ADDU, 1, 0, 0);
        step(0, ADDU, 1, 0, 0);
        step(1, ADDU, 1, 1, 1);
        repeat (3) step(0, ADDU, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom() % 4) != 0, int'($urandom() % NT),
                 ($urandom() % 4) != 0, ($urandom() % 40) == 0,
                 ($urandom() % 300) == 0);
        end
        step(0, ADDU, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
